// File: rtl/remap_table_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : remap_table_ctrl_pkg
// Description : Shared constants, types and helpers for the virtual-to-flash
//               page remapping table. Holds the default geometry, the
//               controller state encoding and the rotating index helper.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package remap_table_ctrl_pkg;

    localparam int unsigned DEF_VPAGES    = 256;
    localparam int unsigned DEF_NBLK      = 32;
    localparam int unsigned DEF_PPB       = 16;
    localparam int unsigned DEF_GC_THRESH = 4;

    typedef logic [$clog2(DEF_VPAGES)-1:0]                  virtual_addr_t;
    typedef logic [$clog2(DEF_NBLK)-1:0]                    block_t;
    typedef logic [$clog2(DEF_NBLK)+$clog2(DEF_PPB)-1:0]    flash_addr_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ALLOC  = 2'd1,
        ST_UPDATE = 2'd2,
        ST_ERASE  = 2'd3
    } rt_state_t;

    // Increment an index modulo n (n need not be a power of two).
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/remap_free_scan.sv
`default_nettype none
// ============================================================================
// Module      : remap_free_scan
// Description : Rotating free-block finder. Tests one candidate block against
//               the free bitmap and produces the next candidate, wrapping
//               NBLK-1 -> 0.
// Ports       : cand      in  BAW   block index under test
//               free_map  in  NBLK  1 = block is free
//               cand_free out 1     candidate is free
//               next_cand out BAW   candidate to test next
// Revision    : 1.0 - initial release
// ============================================================================
module remap_free_scan
    import remap_table_ctrl_pkg::*;
#(
    parameter  int unsigned NBLK = DEF_NBLK,
    localparam int unsigned BAW  = $clog2(NBLK)
) (
    input  logic [BAW-1:0]  cand,
    input  logic [NBLK-1:0] free_map,
    output logic            cand_free,
    output logic [BAW-1:0]  next_cand
);

    assign cand_free = free_map[cand];
    assign next_cand = BAW'(wrap_inc(32'(cand), NBLK));

endmodule
`default_nettype wire

// File: rtl/remap_table_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : remap_table_ctrl
// Description : Virtual-to-flash page remapping table. Keeps the L2P map,
//               per-block valid-page counts and a free-block bitmap; allocates
//               pages sequentially inside one active block.
// Ports       : CLK/RST                 clock, synchronous active-high reset
//               lk_req/lk_vaddr         lookup request (any state)
//               lk_done/lk_hit/lk_paddr registered lookup result
//               wr_req/wr_gc/wr_vaddr   host write or GC relocation
//               wr_ready                controller idle
//               wr_done/wr_paddr        write completion and allocated page
//               er_req/er_blk           erase-complete notification
//               er_done/error           erase accepted / request rejected
//               active_blk              block being filled
//               vcnt_blk/vcnt           valid-page count query
//               free_blks/page_used     occupancy counters
//               gc_needed               free_blks below GC_THRESH
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module remap_table_ctrl
    import remap_table_ctrl_pkg::*;
#(
    parameter  int unsigned VPAGES    = DEF_VPAGES,
    parameter  int unsigned NBLK      = DEF_NBLK,
    parameter  int unsigned PPB       = DEF_PPB,
    parameter  int unsigned GC_THRESH = DEF_GC_THRESH,
    localparam int unsigned VAW       = $clog2(VPAGES),
    localparam int unsigned BAW       = $clog2(NBLK),
    localparam int unsigned POW       = $clog2(PPB),
    localparam int unsigned PAW       = BAW + POW
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           lk_req,
    input  logic [VAW-1:0] lk_vaddr,
    output logic           lk_done,
    output logic           lk_hit,
    output logic [PAW-1:0] lk_paddr,
    input  logic           wr_req,
    input  logic           wr_gc,
    input  logic [VAW-1:0] wr_vaddr,
    output logic           wr_ready,
    output logic           wr_done,
    output logic [PAW-1:0] wr_paddr,
    input  logic           er_req,
    input  logic [BAW-1:0] er_blk,
    output logic           er_done,
    output logic           error,
    output logic [BAW-1:0] active_blk,
    input  logic [BAW-1:0] vcnt_blk,
    output logic [POW:0]   vcnt,
    output logic [BAW:0]   free_blks,
    output logic [VAW:0]   page_used,
    output logic           gc_needed
);

    localparam logic [POW:0] c_wp_full   = (POW+1)'(PPB);
    localparam logic [POW:0] c_vone      = (POW+1)'(1);
    localparam logic [BAW:0] c_bone      = (BAW+1)'(1);
    localparam logic [VAW:0] c_uone      = (VAW+1)'(1);
    localparam logic [BAW:0] c_gc_thresh = (BAW+1)'(GC_THRESH);
    localparam logic [BAW:0] c_free_rst  = (BAW+1)'(NBLK - 1);

    rt_state_t         r_state;
    rt_state_t         w_next_state;

    logic [VPAGES-1:0] r_map_valid;
    logic [PAW-1:0]    r_map_pa [VPAGES];
    logic [POW:0]      r_vcnt   [NBLK];
    logic [NBLK-1:0]   r_free;
    logic [BAW:0]      r_free_blks;
    logic [VAW:0]      r_page_used;
    logic [BAW-1:0]    r_active_blk;
    logic [BAW-1:0]    r_scan;
    logic [BAW-1:0]    r_er_blk;
    logic [POW:0]      r_wp;
    logic [VAW-1:0]    r_vaddr;

    logic              r_lk_done;
    logic              r_lk_hit;
    logic [PAW-1:0]    r_lk_paddr;
    logic              r_wr_done;
    logic [PAW-1:0]    r_wr_paddr;
    logic              r_er_done;
    logic              r_error;

    logic              w_er_bad;
    logic              w_wp_full;
    logic              w_no_free;
    logic              w_acc_er;
    logic              w_acc_wr;
    logic              w_go_alloc;
    logic              w_reject;
    logic              w_cand_free;
    logic [BAW-1:0]    w_scan_in;
    logic [BAW-1:0]    w_next_cand;
    logic              w_old_valid;
    logic [BAW-1:0]    w_old_blk;
    logic [PAW-1:0]    w_new_pa;
    logic [NBLK-1:0]   w_vinc;
    logic [NBLK-1:0]   w_vdec;
    logic              w_unused_gc;

    // Relocations and host writes share one path; the flag is not needed here.
    assign w_unused_gc = wr_gc;

    assign w_er_bad    = (er_blk == r_active_blk) || r_free[er_blk] || (r_vcnt[er_blk] != '0);
    assign w_wp_full   = (r_wp == c_wp_full);
    assign w_no_free   = (r_free_blks == '0);
    assign w_old_valid = r_map_valid[r_vaddr];
    assign w_old_blk   = r_map_pa[r_vaddr][PAW-1 -: BAW];
    assign w_new_pa    = {r_active_blk, r_wp[POW-1:0]};

    // Outside ALLOC the finder is fed the active block, so its next candidate
    // is the scan start point (active_blk + 1, wrapped).
    assign w_scan_in = (r_state == ST_ALLOC) ? r_scan : r_active_blk;

    remap_free_scan #(
        .NBLK      (NBLK)
    ) u_free_scan (
        .cand      (w_scan_in),
        .free_map  (r_free),
        .cand_free (w_cand_free),
        .next_cand (w_next_cand)
    );

    // ---------------- state register ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_acc_er) begin
                    w_next_state = ST_ERASE;
                end else if (w_acc_wr) begin
                    w_next_state = w_go_alloc ? ST_ALLOC : ST_UPDATE;
                end
            end
            ST_ALLOC: begin
                if (w_cand_free) begin
                    w_next_state = ST_UPDATE;
                end
            end
            ST_UPDATE: w_next_state = ST_IDLE;
            ST_ERASE:  w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // ---------------- output / decode logic ----------------
    // Erase wins over write; a rejected request leaves the FSM in IDLE.
    always_comb begin
        wr_ready   = (r_state == ST_IDLE);
        w_acc_er   = 1'b0;
        w_acc_wr   = 1'b0;
        w_go_alloc = 1'b0;
        w_reject   = 1'b0;
        if (r_state == ST_IDLE) begin
            if (er_req) begin
                w_reject = w_er_bad;
                w_acc_er = !w_er_bad;
            end else if (wr_req) begin
                w_reject   = w_wp_full && w_no_free;
                w_acc_wr   = !(w_wp_full && w_no_free);
                w_go_alloc = w_wp_full && !w_no_free;
            end
        end
    end

    // Per-block count deltas for the UPDATE cycle; when the old page sits in
    // the active block both bits hit the same counter and cancel.
    always_comb begin
        w_vinc = '0;
        w_vdec = '0;
        if (r_state == ST_UPDATE) begin
            w_vinc[r_active_blk] = 1'b1;
            if (w_old_valid) begin
                w_vdec[w_old_blk] = 1'b1;
            end
        end
    end

    // ---------------- map data (no reset; qualified by r_map_valid) ----------------
    always_ff @(posedge CLK) begin
        if (r_state == ST_UPDATE) begin
            r_map_pa[r_vaddr] <= w_new_pa;
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_map_valid  <= '0;
            for (int b = 0; b < NBLK; b++) begin
                r_vcnt[b] <= '0;
            end
            r_free       <= {{(NBLK-1){1'b1}}, 1'b0};
            r_free_blks  <= c_free_rst;
            r_page_used  <= '0;
            r_active_blk <= '0;
            r_wp         <= '0;
            r_scan       <= '0;
            r_vaddr      <= '0;
            r_er_blk     <= '0;
            r_lk_done    <= 1'b0;
            r_lk_hit     <= 1'b0;
            r_lk_paddr   <= '0;
            r_wr_done    <= 1'b0;
            r_wr_paddr   <= '0;
            r_er_done    <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            // Lookup reads the pre-update contents, so a same-cycle UPDATE
            // of the same vaddr returns the old mapping.
            r_lk_done  <= lk_req;
            r_lk_hit   <= lk_req && r_map_valid[lk_vaddr];
            r_lk_paddr <= (lk_req && r_map_valid[lk_vaddr]) ? r_map_pa[lk_vaddr] : '0;

            r_wr_done <= (r_state == ST_UPDATE);
            r_er_done <= (r_state == ST_ERASE);
            r_error   <= w_reject;

            if (w_acc_wr) begin
                r_vaddr <= wr_vaddr;
            end
            if (w_acc_er) begin
                r_er_blk <= er_blk;
            end
            if (w_go_alloc) begin
                r_scan <= w_next_cand;
            end

            if (r_state == ST_ALLOC) begin
                if (w_cand_free) begin
                    r_free[r_scan] <= 1'b0;
                    r_free_blks    <= r_free_blks - c_bone;
                    r_active_blk   <= r_scan;
                    r_wp           <= '0;
                end else begin
                    r_scan <= w_next_cand;
                end
            end

            if (r_state == ST_UPDATE) begin
                r_map_valid[r_vaddr] <= 1'b1;
                r_wp                 <= r_wp + c_vone;
                r_wr_paddr           <= w_new_pa;
                if (!w_old_valid) begin
                    r_page_used <= r_page_used + c_uone;
                end
            end

            if (r_state == ST_ERASE) begin
                r_free[r_er_blk] <= 1'b1;
                r_free_blks      <= r_free_blks + c_bone;
            end

            for (int b = 0; b < NBLK; b++) begin
                if (w_vinc[b] && !w_vdec[b]) begin
                    r_vcnt[b] <= r_vcnt[b] + c_vone;
                end else if (w_vdec[b] && !w_vinc[b]) begin
                    r_vcnt[b] <= r_vcnt[b] - c_vone;
                end
            end
        end
    end

    // A valid old mapping always points at a block holding at least that page.
    a_vcnt_no_underflow: assert property (@(posedge CLK) disable iff (RST)
        ((r_state == ST_UPDATE) && w_old_valid) |-> (r_vcnt[w_old_blk] != '0));

    assign lk_done    = r_lk_done;
    assign lk_hit     = r_lk_hit;
    assign lk_paddr   = r_lk_paddr;
    assign wr_done    = r_wr_done;
    assign wr_paddr   = r_wr_paddr;
    assign er_done    = r_er_done;
    assign error      = r_error;
    assign active_blk = r_active_blk;
    assign vcnt       = r_vcnt[vcnt_blk];
    assign free_blks  = r_free_blks;
    assign page_used  = r_page_used;
    assign gc_needed  = (r_free_blks < c_gc_thresh);

endmodule
`default_nettype wire

// File: tb/tb_remap_table_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_remap_table_ctrl
// Description : Self-checking bench for remap_table_ctrl: directed vector
//               table, hand-written multi-cycle sequences and a randomized
//               run against an array-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_remap_table_ctrl;

    localparam int VP  = 256;
    localparam int NB  = 32;
    localparam int PG  = 16;
    localparam int GCT = 4;

    localparam int OP_L = 0;
    localparam int OP_W = 1;
    localparam int OP_E = 2;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       lk_req = 1'b0;
    logic [7:0] lk_vaddr = '0;
    logic       lk_done, lk_hit;
    logic [8:0] lk_paddr;
    logic       wr_req = 1'b0;
    logic       wr_gc = 1'b0;
    logic [7:0] wr_vaddr = '0;
    logic       wr_ready, wr_done;
    logic [8:0] wr_paddr;
    logic       er_req = 1'b0;
    logic [4:0] er_blk = '0;
    logic       er_done, error;
    logic [4:0] active_blk;
    logic [4:0] vcnt_blk = '0;
    logic [4:0] vcnt;
    logic [5:0] free_blks;
    logic [8:0] page_used;
    logic       gc_needed;

    always #5 CLK = ~CLK;

    remap_table_ctrl #(
        .VPAGES(VP), .NBLK(NB), .PPB(PG), .GC_THRESH(GCT)
    ) dut (
        .CLK(CLK), .RST(RST),
        .lk_req(lk_req), .lk_vaddr(lk_vaddr), .lk_done(lk_done), .lk_hit(lk_hit), .lk_paddr(lk_paddr),
        .wr_req(wr_req), .wr_gc(wr_gc), .wr_vaddr(wr_vaddr), .wr_ready(wr_ready),
        .wr_done(wr_done), .wr_paddr(wr_paddr),
        .er_req(er_req), .er_blk(er_blk), .er_done(er_done), .error(error),
        .active_blk(active_blk), .vcnt_blk(vcnt_blk), .vcnt(vcnt),
        .free_blks(free_blks), .page_used(page_used), .gc_needed(gc_needed)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    bit m_valid [VP];
    int m_pa    [VP];
    int m_vcnt  [NB];
    bit m_free  [NB];
    int m_active, m_wp, m_free_blks, m_used;

    function automatic void m_reset();
        for (int i = 0; i < VP; i++) begin m_valid[i] = 1'b0; m_pa[i] = 0; end
        for (int b = 0; b < NB; b++) begin m_vcnt[b] = 0; m_free[b] = (b != 0); end
        m_active = 0; m_wp = 0; m_free_blks = NB - 1; m_used = 0;
    endfunction

    // Returns 1 if accepted; pa = allocated page, lat = cycles to wr_done
    // (or to the error pulse when rejected).
    function automatic bit m_write(input int va, output int pa, output int lat);
        int k;
        lat = 2; pa = 0;
        if (m_wp == PG) begin
            if (m_free_blks == 0) begin lat = 1; return 1'b0; end
            k = 1;
            while (!m_free[(m_active + k) % NB]) k++;
            m_active = (m_active + k) % NB;
            m_free[m_active] = 1'b0;
            m_free_blks--;
            m_wp = 0;
            lat = 2 + k;
        end
        if (m_valid[va]) m_vcnt[m_pa[va] / PG]--;
        else             m_used++;
        m_pa[va] = m_active * PG + m_wp;
        m_valid[va] = 1'b1;
        m_vcnt[m_active]++;
        m_wp++;
        pa = m_pa[va];
        return 1'b1;
    endfunction

    function automatic bit m_erase(input int b);
        if (b == m_active || m_free[b] || m_vcnt[b] != 0) return 1'b0;
        m_free[b] = 1'b1;
        m_free_blks++;
        return 1'b1;
    endfunction

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge CLK); #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (wr_ready !== 1'b1 && n < 50) begin step(); n++; end
        if (wr_ready !== 1'b1) check("wr_ready timeout", 32'(wr_ready), 1);
    endtask

    task automatic do_reset();
        RST = 1'b1; lk_req = 1'b0; wr_req = 1'b0; er_req = 1'b0;
        step(); step();
        RST = 1'b0;
        m_reset();
    endtask

    task automatic dut_write(input int va, input bit gc, output int pa, output int lat, output bit err);
        wait_ready();
        wr_req = 1'b1; wr_gc = gc; wr_vaddr = 8'(va);
        step();
        // Drop the request and scramble the address: the DUT must have latched it.
        wr_req = 1'b0; wr_vaddr = 8'($urandom);
        lat = 1;
        while (wr_done !== 1'b1 && error !== 1'b1 && lat < 64) begin step(); lat++; end
        err = (error === 1'b1);
        pa  = (wr_done === 1'b1) ? int'(wr_paddr) : 0;
        if (wr_done !== 1'b1 && error !== 1'b1) check("write timeout", 0, 1);
    endtask

    task automatic dut_erase(input int b, output bit err);
        int n;
        wait_ready();
        er_req = 1'b1; er_blk = 5'(b);
        step();
        er_req = 1'b0; er_blk = 5'($urandom);
        err = (error === 1'b1);
        if (!err) begin
            n = 0;
            while (er_done !== 1'b1 && n < 8) begin step(); n++; end
            if (er_done !== 1'b1) check("erase timeout", 0, 1);
        end
    endtask

    task automatic dut_lookup(input int va, output bit done, output bit hit, output int pa);
        lk_req = 1'b1; lk_vaddr = 8'(va);
        step();
        lk_req = 1'b0;
        done = lk_done; hit = lk_hit; pa = int'(lk_paddr);
    endtask

    task automatic write_chk(input int va, input bit gc, input string tag);
        int epa, elat, apa, alat;
        bit eok, aerr;
        eok = m_write(va, epa, elat);
        dut_write(va, gc, apa, alat, aerr);
        check($sformatf("%s err va=%0d", tag, va), 32'(aerr), 32'(!eok));
        check($sformatf("%s latency va=%0d", tag, va), alat, elat);
        if (eok) check($sformatf("%s paddr va=%0d", tag, va), apa, epa);
    endtask

    task automatic erase_chk(input int b, input string tag);
        bit eok, aerr;
        eok = m_erase(b);
        dut_erase(b, aerr);
        check($sformatf("%s err blk=%0d", tag, b), 32'(aerr), 32'(!eok));
    endtask

    task automatic lookup_chk(input int va, input string tag);
        bit d, h;
        int p;
        dut_lookup(va, d, h, p);
        check($sformatf("%s done va=%0d", tag, va), 32'(d), 1);
        check($sformatf("%s hit va=%0d", tag, va), 32'(h), 32'(m_valid[va]));
        check($sformatf("%s paddr va=%0d", tag, va), p, m_valid[va] ? m_pa[va] : 0);
    endtask

    task automatic state_chk(input string tag);
        int b;
        b = $urandom_range(0, NB - 1);
        vcnt_blk = 5'(b);
        #1;
        check($sformatf("%s vcnt[%0d]", tag, b), 32'(vcnt), m_vcnt[b]);
        check($sformatf("%s free_blks", tag), 32'(free_blks), m_free_blks);
        check($sformatf("%s page_used", tag), 32'(page_used), m_used);
        check($sformatf("%s gc_needed", tag), 32'(gc_needed), 32'(m_free_blks < GCT));
        check($sformatf("%s active_blk", tag), 32'(active_blk), m_active);
    endtask

    typedef struct {
        int op; int va; int e_err; int e_pa; int e_hit; int e_used; int e_v0; int e_free;
    } vec_t;

    vec_t tbl [8];

    initial begin
        bit d, h, e;
        int p, lat, dummy_pa, dummy_lat;

        tbl[0] = '{OP_L, 5, 0, 0, 0, 0, 0, 31};
        tbl[1] = '{OP_W, 5, 0, 0, 0, 1, 1, 31};
        tbl[2] = '{OP_W, 7, 0, 1, 0, 2, 2, 31};
        tbl[3] = '{OP_L, 5, 0, 0, 1, 2, 2, 31};
        tbl[4] = '{OP_L, 7, 0, 1, 1, 2, 2, 31};
        tbl[5] = '{OP_L, 9, 0, 0, 0, 2, 2, 31};
        tbl[6] = '{OP_E, 0, 1, 0, 0, 2, 2, 31};
        tbl[7] = '{OP_E, 3, 1, 0, 0, 2, 2, 31};

        // ---------------- reset state ----------------
        do_reset();
        check("rst lk_done", 32'(lk_done), 0);
        check("rst wr_done", 32'(wr_done), 0);
        check("rst error", 32'(error), 0);
        check("rst wr_ready", 32'(wr_ready), 1);
        check("rst active_blk", 32'(active_blk), 0);
        check("rst free_blks", 32'(free_blks), 31);
        check("rst page_used", 32'(page_used), 0);
        check("rst gc_needed", 32'(gc_needed), 0);

        // ---------------- vector table ----------------
        for (int i = 0; i < 8; i++) begin
            case (tbl[i].op)
                OP_L: begin
                    dut_lookup(tbl[i].va, d, h, p);
                    check($sformatf("tbl%0d lk_done", i), 32'(d), 1);
                    check($sformatf("tbl%0d lk_hit", i), 32'(h), tbl[i].e_hit);
                    check($sformatf("tbl%0d lk_paddr", i), p, tbl[i].e_pa);
                end
                OP_W: begin
                    void'(m_write(tbl[i].va, dummy_pa, dummy_lat));
                    dut_write(tbl[i].va, 1'b0, p, lat, e);
                    check($sformatf("tbl%0d wr err", i), 32'(e), tbl[i].e_err);
                    check($sformatf("tbl%0d wr_paddr", i), p, tbl[i].e_pa);
                    check($sformatf("tbl%0d wr latency", i), lat, 2);
                end
                default: begin
                    void'(m_erase(tbl[i].va));
                    dut_erase(tbl[i].va, e);
                    check($sformatf("tbl%0d er err", i), 32'(e), tbl[i].e_err);
                end
            endcase
            vcnt_blk = 5'd0;
            #1;
            check($sformatf("tbl%0d page_used", i), 32'(page_used), tbl[i].e_used);
            check($sformatf("tbl%0d vcnt0", i), 32'(vcnt), tbl[i].e_v0);
            check($sformatf("tbl%0d free_blks", i), 32'(free_blks), tbl[i].e_free);
        end

        // ---------------- rewrite with same-cycle lookup ----------------
        wait_ready();
        wr_req = 1'b1; wr_vaddr = 8'd5; wr_gc = 1'b0;
        step();                       // accepted, now in UPDATE
        wr_req = 1'b0; lk_req = 1'b1; lk_vaddr = 8'd5;
        step();                       // UPDATE and lookup on the same edge
        lk_req = 1'b0;
        check("rewrite wr_done", 32'(wr_done), 1);
        check("rewrite wr_paddr", 32'(wr_paddr), 32'h002);
        check("rewrite lk_hit", 32'(lk_hit), 1);
        check("rewrite lk old paddr", 32'(lk_paddr), 32'h000);
        void'(m_write(5, dummy_pa, dummy_lat));
        vcnt_blk = 5'd0;
        #1;
        check("rewrite vcnt0", 32'(vcnt), 2);
        check("rewrite page_used", 32'(page_used), 2);
        lookup_chk(5, "rewrite post lookup");

        // ---------------- first ALLOC ----------------
        do_reset();
        for (int i = 0; i < 16; i++) write_chk(i, 1'b0, "fill blk0");
        void'(m_write(16, dummy_pa, dummy_lat));
        dut_write(16, 1'b0, p, lat, e);
        check("alloc err", 32'(e), 0);
        check("alloc wr_paddr", p, 32'h010);
        check("alloc latency", lat, 3);
        check("alloc active_blk", 32'(active_blk), 1);
        check("alloc free_blks", 32'(free_blks), 30);

        // ---------------- GC relocate then erase ----------------
        erase_chk(0, "erase busy blk0");
        check("erase busy free_blks", 32'(free_blks), 30);
        for (int i = 0; i < 16; i++) write_chk(i, 1'b1, "relocate");
        vcnt_blk = 5'd0;
        #1;
        check("relocated vcnt0", 32'(vcnt), 0);
        check("relocated free_blks", 32'(free_blks), 29);
        dut_erase(0, e);
        void'(m_erase(0));
        check("erase blk0 err", 32'(e), 0);
        check("erase blk0 free_blks", 32'(free_blks), 30);
        erase_chk(0, "erase already free");
        state_chk("gc state");

        // ---------------- randomized run ----------------
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int r, b;
            r = $urandom_range(0, 99);
            if (r < 60) begin
                write_chk($urandom_range(0, 47), 1'($urandom_range(0, 1)), "rnd write");
            end else if (r < 85) begin
                lookup_chk($urandom_range(0, 63), "rnd lookup");
            end else begin
                b = $urandom_range(0, NB - 1);
                if ($urandom_range(0, 1) == 1) begin
                    for (int k = 0; k < NB; k++) begin
                        if (!m_free[k] && k != m_active && m_vcnt[k] == 0) begin b = k; break; end
                    end
                end
                erase_chk(b, "rnd erase");
            end
            state_chk("rnd state");
        end

        // ---------------- exhaustion, wrap-around and reset mid-ALLOC ----------------
        do_reset();
        for (int i = 0; i < NB * PG; i++) write_chk(i % VP, 1'b0, "exhaust");
        check("exhaust free_blks", 32'(free_blks), 0);
        check("exhaust gc_needed", 32'(gc_needed), 1);
        check("exhaust page_used", 32'(page_used), 256);
        write_chk(3, 1'b0, "full write");
        dut_lookup(3, d, h, p);
        check("full map kept", p, m_pa[3]);
        erase_chk(5, "erase blk5");
        check("blk5 free_blks", 32'(free_blks), 1);
        check("blk5 gc_needed", 32'(gc_needed), 1);
        wait_ready();
        wr_req = 1'b1; wr_vaddr = 8'd3;
        step();                       // accepted into ALLOC (scan starts at block 0)
        wr_req = 1'b0;
        step(); step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        m_reset();
        check("midrst wr_ready", 32'(wr_ready), 1);
        check("midrst free_blks", 32'(free_blks), 31);
        check("midrst page_used", 32'(page_used), 0);
        check("midrst active_blk", 32'(active_blk), 0);
        check("midrst gc_needed", 32'(gc_needed), 0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("midrst no pulse c%0d", i), 32'({wr_done, error, er_done}), 0);
            step();
        end
        lookup_chk(3, "midrst lookup");
        write_chk(9, 1'b0, "midrst write");
        state_chk("midrst state");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
